// File: rtl/tb_timer_port.sv
//============================================================================
// Module   : tb_timer_port
// Purpose  : Memory-mapped timer/counter peripheral for the tramelblaze I/O bus
//            with prescaled counter, TICK strobe and acknowledged interrupt.
// Options  : TB_TIMER_OVERRUN_EN adds the sticky OVERRUN status flag.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_timer_port #(
   parameter logic [15:0] BASE_ADDR  = 16'h0000,
   parameter logic [15:0] RELOAD_RST = 16'd49999
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] PORT_ID,
   input  logic [15:0] OUT_PORT,
   input  logic        WRITE_STROBE,
   input  logic        READ_STROBE,
   input  logic        INTERRUPT_ACK,
   output logic [15:0] IN_PORT,
   output logic        INTERRUPT,
   output logic [15:0] COUNT,
   output logic        TICK
);

   localparam logic [15:0] c_ADDR_CTRL   = BASE_ADDR;
   localparam logic [15:0] c_ADDR_RELOAD = BASE_ADDR + 16'd1;
   localparam logic [15:0] c_ADDR_COUNT  = BASE_ADDR + 16'd2;
   localparam logic [15:0] c_ADDR_STATUS = BASE_ADDR + 16'd3;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_ctrl;
   logic [15:0] r_reload;
   logic [15:0] r_count;
   logic [15:0] r_div;
   logic        r_tick;
   logic        w_overrun;

   logic w_run;
   logic w_irq_en;
   logic w_down;
   logic w_wr_ctrl;
   logic w_wr_reload;
   logic w_wr_count;
   logic w_wrap;
   logic w_irq_wrap;

   assign w_run    = r_ctrl[0];
   assign w_irq_en = r_ctrl[1];
   assign w_down   = r_ctrl[2];

   assign w_wr_ctrl   = WRITE_STROBE && (PORT_ID == c_ADDR_CTRL);
   assign w_wr_reload = WRITE_STROBE && (PORT_ID == c_ADDR_RELOAD);
   assign w_wr_count  = WRITE_STROBE && (PORT_ID == c_ADDR_COUNT);

   assign w_wrap     = w_run && (r_div == r_reload);
   assign w_irq_wrap = w_wrap && w_irq_en;

   // Control and reload registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_ctrl   <= 3'b000;
         r_reload <= RELOAD_RST;
      end else begin
         if (w_wr_ctrl)
            r_ctrl <= OUT_PORT[2:0];
         if (w_wr_reload)
            r_reload <= OUT_PORT;
      end
   end

   // Prescaler: a RELOAD write restarts the period from zero
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_div  <= 16'h0000;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         if (w_wr_reload)
            r_div <= 16'h0000;
         else if (w_wrap)
            r_div <= 16'h0000;
         else if (w_run)
            r_div <= r_div + 16'd1;
      end
   end

   // Counter: a software load takes priority over a coincident wrap
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_count <= 16'h0000;
      end else if (w_wr_count) begin
         r_count <= OUT_PORT;
      end else if (w_wrap) begin
         if (w_down)
            r_count <= r_count - 16'd1;
         else
            r_count <= r_count + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // A new request coincident with ACK keeps the interrupt pending
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_irq_wrap)
               w_state_next = S_PEND;
         end
         S_PEND: begin
            if (INTERRUPT_ACK && !w_irq_wrap)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

`ifdef TB_TIMER_OVERRUN_EN
   logic r_overrun;
   logic w_overrun_set;
   logic w_status_read;

   assign w_overrun_set = (r_state == S_PEND) && w_irq_wrap && !INTERRUPT_ACK;
   assign w_status_read = READ_STROBE && (PORT_ID == c_ADDR_STATUS);

   // Set wins over a simultaneous status read so no miss goes unreported
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_overrun <= 1'b0;
      else if (w_overrun_set)
         r_overrun <= 1'b1;
      else if (w_status_read)
         r_overrun <= 1'b0;
   end

   assign w_overrun = r_overrun;
`else
   logic w_unused_read_strobe;

   assign w_unused_read_strobe = READ_STROBE;
   assign w_overrun            = 1'b0;
`endif

   always_comb begin
      IN_PORT = 16'h0000;
      if (PORT_ID == c_ADDR_CTRL)
         IN_PORT = {13'd0, r_ctrl};
      else if (PORT_ID == c_ADDR_RELOAD)
         IN_PORT = r_reload;
      else if (PORT_ID == c_ADDR_COUNT)
         IN_PORT = r_count;
      else if (PORT_ID == c_ADDR_STATUS)
         IN_PORT = {14'd0, w_overrun, INTERRUPT};
   end

   assign INTERRUPT = (r_state == S_PEND);
   assign COUNT     = r_count;
   assign TICK      = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_tb_timer_port.sv
//============================================================================
// Module   : tb_tb_timer_port
// Purpose  : Directed self-checking bench for tb_timer_port (BASE_ADDR = 0).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_tb_timer_port;

   logic        CLK;
   logic        RESET;
   logic [15:0] PORT_ID;
   logic [15:0] OUT_PORT;
   logic        WRITE_STROBE;
   logic        READ_STROBE;
   logic        INTERRUPT_ACK;
   logic [15:0] IN_PORT;
   logic        INTERRUPT;
   logic [15:0] COUNT;
   logic        TICK;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef TB_TIMER_OVERRUN_EN
   localparam logic [15:0] c_STATUS_OVR = 16'h0003;
`else
   localparam logic [15:0] c_STATUS_OVR = 16'h0001;
`endif

   tb_timer_port #(
      .BASE_ADDR  (16'h0000),
      .RELOAD_RST (16'd49999)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .PORT_ID       (PORT_ID),
      .OUT_PORT      (OUT_PORT),
      .WRITE_STROBE  (WRITE_STROBE),
      .READ_STROBE   (READ_STROBE),
      .INTERRUPT_ACK (INTERRUPT_ACK),
      .IN_PORT       (IN_PORT),
      .INTERRUPT     (INTERRUPT),
      .COUNT         (COUNT),
      .TICK          (TICK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the write edge
   task automatic wr(input logic [15:0] addr, input logic [15:0] data);
      PORT_ID      = addr;
      OUT_PORT     = data;
      WRITE_STROBE = 1'b1;
      @(negedge CLK);
      WRITE_STROBE = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      PORT_ID = addr;
      #1;
      chk(tag, IN_PORT, exp);
   endtask

   task automatic ack_pulse();
      INTERRUPT_ACK = 1'b1;
      @(negedge CLK);
      INTERRUPT_ACK = 1'b0;
   endtask

   initial begin
      RESET         = 1'b0;
      PORT_ID       = 16'h0000;
      OUT_PORT      = 16'h0000;
      WRITE_STROBE  = 1'b0;
      READ_STROBE   = 1'b0;
      INTERRUPT_ACK = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      // Reset state and register map
      chk("rst_count", COUNT, 16'h0000);
      chk("rst_irq", {15'd0, INTERRUPT}, 16'h0000);
      chk("rst_tick", {15'd0, TICK}, 16'h0000);
      rd("rst_reload", 16'h0001, 16'hC34F);
      rd("rst_status", 16'h0003, 16'h0000);
      rd("unmapped", 16'h0004, 16'h0000);
      wr(16'h0003, 16'hFFFF);
      rd("status_ro", 16'h0003, 16'h0000);
      wr(16'h0000, 16'hFFFF);
      rd("ctrl_mask", 16'h0000, 16'h0007);
      wr(16'h0000, 16'h0000);

      // Count up with RELOAD=3: one wrap every 4 cycles
      wr(16'h0001, 16'h0003);
      rd("reload_rb", 16'h0001, 16'h0003);
      wr(16'h0000, 16'h0001);
      for (int k = 1; k <= 3; k++) begin
         repeat (3) @(negedge CLK);
         chk($sformatf("up_notick%0d", k), {15'd0, TICK}, 16'h0000);
         @(negedge CLK);
         chk($sformatf("up_tick%0d", k), {15'd0, TICK}, 16'h0001);
         chk($sformatf("up_count%0d", k), COUNT, 16'(k));
      end

      // Clearing RUN freezes the count
      wr(16'h0000, 16'h0000);
      repeat (6) @(negedge CLK);
      chk("frozen_count", COUNT, 16'h0003);
      chk("frozen_tick", {15'd0, TICK}, 16'h0000);

      // Up wrap FFFF->0000 with RELOAD=0 (tick every cycle)
      wr(16'h0002, 16'hFFFF);
      wr(16'h0001, 16'h0000);
      wr(16'h0000, 16'h0001);
      @(negedge CLK);
      chk("wrap_up", COUNT, 16'h0000);
      chk("wrap_up_tick", {15'd0, TICK}, 16'h0001);
      @(negedge CLK);
      chk("reload0_count", COUNT, 16'h0001);
      chk("reload0_tick", {15'd0, TICK}, 16'h0001);

      // Down wrap 0000->FFFF
      wr(16'h0000, 16'h0000);
      wr(16'h0002, 16'h0000);
      wr(16'h0000, 16'h0005);
      @(negedge CLK);
      chk("wrap_down", COUNT, 16'hFFFF);
      wr(16'h0000, 16'h0000);
      chk("down_step", COUNT, 16'hFFFE);

      // Write to COUNT on the wrap edge wins
      wr(16'h0001, 16'h0003);
      wr(16'h0002, 16'h0000);
      wr(16'h0000, 16'h0001);
      repeat (3) @(negedge CLK);
      wr(16'h0002, 16'h1234);
      chk("coll_count", COUNT, 16'h1234);
      chk("coll_tick", {15'd0, TICK}, 16'h0001);

      // RELOAD write mid-period restarts the prescaler
      repeat (2) @(negedge CLK);
      wr(16'h0001, 16'h0003);
      repeat (3) @(negedge CLK);
      chk("restart_notick", {15'd0, TICK}, 16'h0000);
      chk("restart_hold", COUNT, 16'h1234);
      @(negedge CLK);
      chk("restart_tick", {15'd0, TICK}, 16'h0001);
      chk("restart_count", COUNT, 16'h1235);
      wr(16'h0000, 16'h0000);

      // Interrupt handshake with RELOAD=9
      wr(16'h0001, 16'h0009);
      wr(16'h0002, 16'h0000);
      wr(16'h0000, 16'h0003);
      repeat (9) @(negedge CLK);
      chk("irq_before", {15'd0, INTERRUPT}, 16'h0000);
      @(negedge CLK);
      chk("irq_rise", {15'd0, INTERRUPT}, 16'h0001);
      chk("irq_rise_tick", {15'd0, TICK}, 16'h0001);
      rd("status_pend", 16'h0003, 16'h0001);
      repeat (3) @(negedge CLK);
      chk("irq_hold", {15'd0, INTERRUPT}, 16'h0001);
      ack_pulse();
      chk("irq_ack", {15'd0, INTERRUPT}, 16'h0000);

      // ACK coincident with a wrap keeps the request pending, no overrun
      repeat (6) @(negedge CLK);
      chk("irq_second", {15'd0, INTERRUPT}, 16'h0001);
      repeat (9) @(negedge CLK);
      ack_pulse();
      chk("ack_wrap_irq", {15'd0, INTERRUPT}, 16'h0001);
      chk("ack_wrap_tick", {15'd0, TICK}, 16'h0001);
      rd("ack_wrap_status", 16'h0003, 16'h0001);

      // Unacknowledged wrap while pending
      repeat (10) @(negedge CLK);
      rd("overrun_status", 16'h0003, c_STATUS_OVR);
      READ_STROBE = 1'b1;
      @(negedge CLK);
      READ_STROBE = 1'b0;
      rd("overrun_clear", 16'h0003, 16'h0001);

      // Clearing IRQ_EN keeps the pending request; ACK in IDLE is ignored
      wr(16'h0000, 16'h0001);
      chk("irqen_off_hold", {15'd0, INTERRUPT}, 16'h0001);
      ack_pulse();
      chk("irqen_off_ack", {15'd0, INTERRUPT}, 16'h0000);
      repeat (12) @(negedge CLK);
      chk("irqen_off_quiet", {15'd0, INTERRUPT}, 16'h0000);
      ack_pulse();
      chk("ack_idle", {15'd0, INTERRUPT}, 16'h0000);

      // Asynchronous reset mid-operation
      wr(16'h0002, 16'h0055);
      wr(16'h0000, 16'h0003);
      repeat (12) @(negedge CLK);
      chk("pre_reset_irq", {15'd0, INTERRUPT}, 16'h0001);
      PORT_ID = 16'h0001;
      #2;
      RESET = 1'b0;
      #1;
      chk("async_count", COUNT, 16'h0000);
      chk("async_irq", {15'd0, INTERRUPT}, 16'h0000);
      chk("async_tick", {15'd0, TICK}, 16'h0000);
      chk("async_reload", IN_PORT, 16'hC34F);
      @(negedge CLK);
      RESET = 1'b1;
      rd("post_reset_ctrl", 16'h0000, 16'h0000);
      repeat (3) @(negedge CLK);
      chk("post_reset_count", COUNT, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
